program_loader: RTL and testbench
=================================

# program_loader

Memory-side writer for the 8-bit CPU: accepts a byte stream over a valid/ready handshake and writes it into the 32-entry program/data memory that the CPU datapath reads. While loading, it holds the CPU datapath in reset so instruction fetch never sees a partially written image. It sits between an external byte source (host link or boot ROM) and the memory write port. It releases the CPU once the image is complete and, optionally, checksum-verified.

## Interface
- ADDR_W, 5, memory address width; matches the CPU's 5-bit address.
- DATA_W, 8, memory word width.
- DEPTH, 32, number of memory words; must equal 2**ADDR_W.
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a load; sampled only in IDLE or ERR.
- in_valid  input  1  source has a byte on in_data.
- in_data  input  DATA_W  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_write_en  output  1  one-cycle memory write strobe.
- mem_address  output  ADDR_W  write address.
- mem_data  output  DATA_W  write data; the integration drives the memory's tristate bus from this only while mem_write_en=1.
- cpu_rst  output  1  hold for the CPU datapath reset.
- busy  output  1  load in progress.
- done  output  1  one-cycle pulse on successful completion.
- error  output  1  sticky load failure flag.

## Operation
- Stream format: one header byte N, then the data bytes, then (macro only) one checksum byte. N=0 means DEPTH bytes; N in 1..DEPTH means N bytes; N>DEPTH is an error.
- Handshake: a byte transfers on a rising edge with in_valid=1 and in_ready=1. in_ready=1 exactly in states HDR, DATA and CSUM. Throughput is one byte per cycle; back-to-back transfers are legal.
- States:
  - IDLE: start=1 → HDR; clear count and sum.
  - HDR: accept header. N>DEPTH → ERR. Otherwise latch remaining = (N==0 ? DEPTH : N) → DATA.
  - DATA: accept byte k at address k, starting from 0. After the last byte: CSUM if the macro is defined, else DONE.
  - CSUM: accept checksum. If it matches → DONE, else → ERR.
  - DONE: lasts one cycle, then → IDLE.
  - ERR: holds until start=1 → HDR. The start that leaves ERR clears error.
- Writes: a data-byte handshake in cycle t produces mem_write_en=1 in cycle t+1, with mem_address=k and mem_data equal to that byte. All three outputs are registered. Header and checksum bytes never write.
- Count is ADDR_W+1 bits so that DEPTH=32 is representable. Addresses never wrap; exactly N writes occur.
- busy=1 in HDR, DATA, CSUM and DONE. cpu_rst=1 in every state except IDLE, and also during rst.
- start while busy is ignored. in_valid outside HDR/DATA/CSUM is ignored and never acknowledged.

## Timing
- Reset values: state IDLE, in_ready=0, mem_write_en=0, mem_address=0, mem_data=0, cpu_rst=1, busy=0, done=0, error=0.
- First cycle after rst deasserts: cpu_rst=0 (IDLE), so a preloaded memory image runs unchanged.
- start high at edge e → from e: HDR, in_ready=1, busy=1, cpu_rst=1.
- Last data handshake at edge t (no macro) → final write and done=1 during cycle t..t+1. From t+1: IDLE, busy=0, cpu_rst=0.
- With the macro, checksum handshake at edge c → done=1 or error=1 from c. cpu_rst drops at c+1 only on success.
- rst mid-load: outputs return to reset values immediately. Bytes already written remain in memory. No pending write is issued.

## Configuration
- PROGRAM_LOADER_CHECKSUM_EN defined: keep a running 8-bit sum of the data bytes (mod 256, header excluded). A trailing checksum byte is required and must equal that sum. On mismatch, enter ERR with cpu_rst held high.
- Undefined: no CSUM state and no sum register. DATA goes directly to DONE, and error is raised only for N>DEPTH.

## Test plan
- Header 3, bytes A0 A1 A2 back-to-back → writes (0,A0) (1,A1) (2,A2) on consecutive cycles; done pulses once; cpu_rst falls the next cycle.
- Header 0 followed by 32 bytes → 32 writes at addresses 0..31, no wrap, then done; a 33rd valid byte gets in_ready=0.
- Header 33 → error=1, no mem_write_en, cpu_rst stays 1; a subsequent start clears error and a valid load completes.
- in_valid toggling 1/0 during a 4-byte load → only handshaked bytes are written, with addresses contiguous.
- rst asserted after 2 of 5 bytes → outputs return to reset values asynchronously, no further writes, cpu_rst=0 after release.
- Macro on: bytes 01 02 03 with checksum 06 → done. Same bytes with checksum 07 → error=1, cpu_rst held high.

Source files
------------

// File: rtl/program_loader.sv
// Byte-stream loader for the 32-word CPU program memory; holds the CPU in reset while loading.
// Optional trailing checksum verification enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam int LEN_W = ADDR_W + 1;
  localparam logic [DATA_W-1:0] DEPTH_B = DATA_W'(DEPTH);
  localparam logic [LEN_W-1:0]  DEPTH_L = LEN_W'(DEPTH);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_DONE, S_ERR} state_t;
`endif

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  wr_t              wr_q, wr_d;
  logic             hs;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
`endif

  assign hs = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    wr_d    = '{en: 1'b0, addr: wr_q.addr, data: wr_q.data};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          state_d = S_HDR;
          cnt_d   = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      S_HDR: begin
        if (hs) begin
          if (in_data > DEPTH_B) begin
            state_d = S_ERR;
          end else begin
            // header 0 encodes a full-memory image
            len_d   = (in_data == '0) ? DEPTH_L : in_data[LEN_W-1:0];
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (hs) begin
          wr_d  = '{en: 1'b1, addr: cnt_q[ADDR_W-1:0], data: in_data};
          cnt_d = cnt_q + LEN_W'(1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          sum_d = sum_q + in_data;
          if (cnt_d == len_q) state_d = S_CSUM;
`else
          if (cnt_d == len_q) state_d = S_DONE;
`endif
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (hs) state_d = (in_data == sum_q) ? S_DONE : S_ERR;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      wr_q    <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      wr_q    <= wr_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  assign in_ready = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
`else
  assign in_ready = (state_q == S_HDR) || (state_q == S_DATA);
`endif
  assign busy         = in_ready || (state_q == S_DONE);
  // rst feeds cpu_rst directly so the CPU is held even before the state register settles
  assign cpu_rst      = rst || (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign error        = (state_q == S_ERR);
  assign mem_write_en = wr_q.en;
  assign mem_address  = wr_q.addr;
  assign mem_data     = wr_q.data;
endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: random loads against a queue-based write model.
module tb_program_loader;
  localparam int DEPTH = 32;

  logic       clk = 1'b0;
  logic       rst, start, in_valid;
  logic [7:0] in_data;
  logic       in_ready, mem_write_en, cpu_rst, busy, done, error;
  logic [4:0] mem_address;
  logic [7:0] mem_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;

  typedef struct {
    logic [4:0] a;
    logic [7:0] d;
    int         c;
  } obs_t;
  obs_t obs_q[$];

  logic [7:0] pl [64];

  program_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_write_en(mem_write_en), .mem_address(mem_address),
    .mem_data(mem_data), .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (mem_write_en) obs_q.push_back('{a: mem_address, d: mem_data, c: cyc});
      if (done) done_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Drive one byte and wait (bounded) for its handshake; leaves in_valid high.
  task automatic send(input logic [7:0] b);
    bit hs;
    int n;
    in_valid = 1'b1; in_data = b; hs = 0; n = 0;
    while (!hs && n < 50) begin
      @(negedge clk); hs = in_ready;
      step();
      n++;
    end
    checks++;
    if (!hs) begin errors++; $display("FAIL send_timeout byte=%h in_ready stayed 0", b); end
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) pl[i] = 8'($urandom);
  endtask

  task automatic run_load(input int hdr, input int gap_max, input bit bad, input bit chk_b2b);
    int len, d0;
    logic [7:0] sum;
    len = (hdr == 0) ? DEPTH : hdr;
    in_valid = 1'b0;
    obs_q.delete();
    d0 = done_cnt;
    pulse_start();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1 || cpu_rst !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL start_state got rdy=%b busy=%b cpu_rst=%b err=%b want 1 1 1 0", in_ready, busy, cpu_rst, error);
    end
    send(8'(hdr));
    sum = 8'h00;
    for (int i = 0; i < len; i++) begin
      if (gap_max > 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, gap_max)) begin
          start = 1'($urandom_range(0, 1));
          step();
        end
        start = 1'b0;
      end
      send(pl[i]);
      sum = sum + pl[i];
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send(bad ? sum + 8'h01 : sum);
`endif
    checks++;
    if (!bad) begin
      if (done !== 1'b1 || busy !== 1'b1 || cpu_rst !== 1'b1 || in_ready !== 1'b0 || error !== 1'b0) begin
        errors++;
        $display("FAIL end_state got done=%b busy=%b cpu_rst=%b rdy=%b err=%b want 1 1 1 0 0", done, busy, cpu_rst, in_ready, error);
      end
    end else begin
      if (error !== 1'b1 || done !== 1'b0 || cpu_rst !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL csum_err_state got err=%b done=%b cpu_rst=%b busy=%b want 1 0 1 0", error, done, cpu_rst, busy);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (!bad) begin
      if (done !== 1'b0 || busy !== 1'b0 || cpu_rst !== 1'b0) begin
        errors++;
        $display("FAIL release got done=%b busy=%b cpu_rst=%b want 0 0 0", done, busy, cpu_rst);
      end
    end else begin
      if (error !== 1'b1 || cpu_rst !== 1'b1) begin
        errors++;
        $display("FAIL err_hold got err=%b cpu_rst=%b want 1 1", error, cpu_rst);
      end
    end
    step();
    checks++;
    if (obs_q.size() != len) begin
      errors++;
      $display("FAIL write_count got %0d want %0d", obs_q.size(), len);
    end else begin
      for (int i = 0; i < len; i++) begin
        checks++;
        if (obs_q[i].a !== 5'(i) || obs_q[i].d !== pl[i]) begin
          errors++;
          $display("FAIL write_%0d got (%0d,%h) want (%0d,%h)", i, obs_q[i].a, obs_q[i].d, i, pl[i]);
        end
        if (chk_b2b && i > 0) begin
          checks++;
          if (obs_q[i].c != obs_q[i-1].c + 1) begin
            errors++;
            $display("FAIL b2b_cycle_%0d got gap=%0d want 1", i, obs_q[i].c - obs_q[i-1].c);
          end
        end
      end
    end
    checks++;
    if (done_cnt - d0 != (bad ? 0 : 1)) begin
      errors++;
      $display("FAIL done_pulses got %0d want %0d", done_cnt - d0, bad ? 0 : 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #23;
    checks++;
    if (in_ready !== 1'b0 || mem_write_en !== 1'b0 || mem_address !== 5'd0 || mem_data !== 8'h00 ||
        cpu_rst !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL reset_values got rdy=%b we=%b a=%0d d=%h cpu_rst=%b busy=%b done=%b err=%b",
               in_ready, mem_write_en, mem_address, mem_data, cpu_rst, busy, done, error);
    end
    @(posedge clk); #1; rst = 1'b0; #1;
    checks++;
    if (cpu_rst !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset got cpu_rst=%b busy=%b want 0 0", cpu_rst, busy);
    end
    step();
  endtask

  task automatic test_back_to_back();
    pl[0] = 8'hA0; pl[1] = 8'hA1; pl[2] = 8'hA2;
    run_load(3, 0, 0, 1);
  endtask

  task automatic test_full_depth();
    int n;
    fill_rand(DEPTH);
    run_load(0, 0, 0, 1);
    n = obs_q.size();
    in_valid = 1'b1; in_data = 8'h5A;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL extra_byte_ready got %b want 0", in_ready); end
      step();
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (obs_q.size() != n) begin errors++; $display("FAIL extra_byte_write got %0d writes want %0d", obs_q.size(), n); end
  endtask

  task automatic test_bad_header(input logic [7:0] hdr);
    in_valid = 1'b0;
    obs_q.delete();
    pulse_start();
    send(hdr);
    checks++;
    if (error !== 1'b1 || cpu_rst !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL bad_hdr_%0d got err=%b cpu_rst=%b busy=%b rdy=%b done=%b want 1 1 0 0 0",
               hdr, error, cpu_rst, busy, in_ready, done);
    end
    repeat (3) step();
    in_valid = 1'b0;
    step();
    checks++;
    if (error !== 1'b1 || cpu_rst !== 1'b1 || obs_q.size() != 0) begin
      errors++;
      $display("FAIL bad_hdr_hold got err=%b cpu_rst=%b writes=%0d want 1 1 0", error, cpu_rst, obs_q.size());
    end
    fill_rand(4);
    run_load(4, 0, 0, 0);
  endtask

  task automatic test_valid_toggle();
    fill_rand(4);
    run_load(4, 2, 0, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      int h;
      h = $urandom_range(1, DEPTH);
      fill_rand(h);
      run_load(h, $urandom_range(0, 2), 0, 0);
    end
  endtask

  task automatic test_mid_reset();
    fill_rand(5);
    in_valid = 1'b0;
    obs_q.delete();
    pulse_start();
    send(8'd5);
    send(pl[0]);
    send(pl[1]);
    in_valid = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || mem_write_en !== 1'b0 || mem_address !== 5'd0 || mem_data !== 8'h00 ||
        cpu_rst !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_values got rdy=%b we=%b a=%0d d=%h cpu_rst=%b busy=%b done=%b err=%b",
               in_ready, mem_write_en, mem_address, mem_data, cpu_rst, busy, done, error);
    end
    in_valid = 1'b1; in_data = pl[2];
    repeat (2) step();
    rst = 1'b0; #1;
    checks++;
    if (cpu_rst !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_release got cpu_rst=%b rdy=%b busy=%b want 0 0 0", cpu_rst, in_ready, busy);
    end
    repeat (2) step();
    in_valid = 1'b0;
    checks++;
    if (obs_q.size() != 2) begin
      errors++;
      $display("FAIL mid_reset_writes got %0d want 2", obs_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_q[i].a !== 5'(i) || obs_q[i].d !== pl[i]) begin
          errors++;
          $display("FAIL mid_reset_write_%0d got (%0d,%h) want (%0d,%h)", i, obs_q[i].a, obs_q[i].d, i, pl[i]);
        end
      end
    end
  endtask

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03;
    run_load(3, 0, 0, 1);
    run_load(3, 0, 1, 1);
    fill_rand(5);
    run_load(5, 0, 0, 0);
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_full_depth();
    test_bad_header(8'd33);
    test_bad_header(8'($urandom_range(34, 255)));
    test_valid_toggle();
    test_random();
    test_mid_reset();
    fill_rand(3);
    run_load(3, 0, 0, 0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
